// File: rtl/dac_ctrl_pkg.sv
// Shared constants, FSM state type and the attenuation ramp step helper for the
// DAC control-bus responder.
package dac_ctrl_pkg;

  localparam logic [6:0] ADDR_ATL   = 7'd16;
  localparam logic [6:0] ADDR_ATR   = 7'd17;
  localparam logic [6:0] ADDR_MUTE  = 7'd18;
  localparam int         FRAME_BITS = 16;
  localparam logic [7:0] ATT_RESET  = 8'hFF;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    IDLE     = 2'd1,
    SHIFT    = 2'd2
  } rx_state_e;

  // One-LSB move of cur toward tgt; holds when already equal.
  function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] nxt;
    if (cur < tgt) begin
      nxt = cur + 8'd1;
    end else if (cur > tgt) begin
      nxt = cur - 8'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a previous-value flop; level, rise and fall are all
// registered and mutually aligned (level is the post-edge value).
module sync_edge (
  input  logic i_clk48,
  input  logic i_rst48_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r, s2_r, s3_r;
  logic rise_r, fall_r;

  // Synchronizer chain and edge detection between the 2nd and 3rd stages.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      s3_r   <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      s1_r   <= din;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      rise_r <= s2_r & ~s3_r;
      fall_r <= ~s2_r & s3_r;
    end
  end

  assign level = s3_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/dac_ctrl_rx.sv
// DAC control-bus responder: decodes 16-bit SEL_n/CLOCK/DATA write frames into
// attenuation and mute registers. Define DAC_CTRL_RX_SOFT_RAMP_EN for stepped attenuation.
module dac_ctrl_rx
  import dac_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = 4800
) (
  input  logic       i_clk48,
  input  logic       i_rst48_n,
  input  logic       i_sel_n,
  input  logic       i_clock,
  input  logic       i_data,
  output logic [7:0] o_att_l,
  output logic [7:0] o_att_r,
  output logic [1:0] o_mute,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_err
);

  if (RAMP_DIV < 1) begin : g_bad_ramp_div
    $error("RAMP_DIV must be at least 1");
  end

  logic sel_lvl_s, sel_rise_s, sel_fall_s;
  logic clk_lvl_s, clk_rise_s, clk_fall_s;
  logic data_s1_r, data_s2_r, data_s3_r;

  sync_edge u_sync_sel (
    .i_clk48(i_clk48), .i_rst48_n(i_rst48_n), .din(i_sel_n),
    .level(sel_lvl_s), .rise(sel_rise_s), .fall(sel_fall_s)
  );

  sync_edge u_sync_clk (
    .i_clk48(i_clk48), .i_rst48_n(i_rst48_n), .din(i_clock),
    .level(clk_lvl_s), .rise(clk_rise_s), .fall(clk_fall_s)
  );

  // DATA gets three stages so it lines up with the registered clock edge.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      data_s1_r <= 1'b0;
      data_s2_r <= 1'b0;
      data_s3_r <= 1'b0;
    end else begin
      data_s1_r <= i_data;
      data_s2_r <= data_s1_r;
      data_s3_r <= data_s2_r;
    end
  end

  rx_state_e   state_r, state_nxt;
  logic [15:0] shift_r, shift_nxt;
  logic [4:0]  cnt_r, cnt_nxt;
  logic        commit_s, err_s;

  // Frame FSM: next state, shift/count update and frame verdict.
  always_comb begin
    state_nxt = state_r;
    shift_nxt = shift_r;
    cnt_nxt   = cnt_r;
    commit_s  = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      DISARMED: begin
        if (sel_lvl_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DISARMED;
        end
      end
      IDLE: begin
        if (sel_fall_s) begin
          cnt_nxt   = 5'd0;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // SEL_n edge takes priority over a coincident CLOCK edge.
        if (sel_rise_s) begin
          state_nxt = IDLE;
          if ((cnt_r == 5'(FRAME_BITS)) && !shift_r[15]) begin
            commit_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else if (clk_rise_s) begin
          shift_nxt = {shift_r[14:0], data_s3_r};
          if (cnt_r != CNT_SAT) begin
            cnt_nxt = cnt_r + 5'd1;
          end else begin
            cnt_nxt = cnt_r;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: begin
        state_nxt = DISARMED;
      end
    endcase
  end

  logic [7:0] att_l_tgt_r, att_r_tgt_r;
  logic [1:0] mute_r;
  logic       wr_valid_r, frame_err_r;
  logic [6:0] wr_addr_r;
  logic [7:0] wr_data_r;

  // FSM state, frame datapath and committed register set.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      state_r     <= DISARMED;
      shift_r     <= 16'h0000;
      cnt_r       <= 5'd0;
      wr_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      wr_addr_r   <= 7'd0;
      wr_data_r   <= 8'h00;
      att_l_tgt_r <= ATT_RESET;
      att_r_tgt_r <= ATT_RESET;
      mute_r      <= 2'b00;
    end else begin
      state_r     <= state_nxt;
      shift_r     <= shift_nxt;
      cnt_r       <= cnt_nxt;
      wr_valid_r  <= commit_s;
      frame_err_r <= err_s;
      if (commit_s) begin
        wr_addr_r <= shift_r[14:8];
        wr_data_r <= shift_r[7:0];
        case (shift_r[14:8])
          ADDR_ATL:  att_l_tgt_r <= shift_r[7:0];
          ADDR_ATR:  att_r_tgt_r <= shift_r[7:0];
          ADDR_MUTE: mute_r      <= shift_r[1:0];
          default:   ;
        endcase
      end
    end
  end

`ifdef DAC_CTRL_RX_SOFT_RAMP_EN
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic [7:0]       att_l_r, att_r_r;

  assign tick_s = (div_r == DIV_W'(RAMP_DIV - 1));

  // Shared free-running divider and one-LSB steps toward the targets.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      div_r   <= '0;
      att_l_r <= ATT_RESET;
      att_r_r <= ATT_RESET;
    end else begin
      if (tick_s) begin
        div_r   <= '0;
        att_l_r <= ramp_step(att_l_r, att_l_tgt_r);
        att_r_r <= ramp_step(att_r_r, att_r_tgt_r);
      end else begin
        div_r   <= div_r + DIV_W'(1);
      end
    end
  end

  assign o_att_l = att_l_r;
  assign o_att_r = att_r_r;
`else
  assign o_att_l = att_l_tgt_r;
  assign o_att_r = att_r_tgt_r;
`endif

  assign o_mute      = mute_r;
  assign o_wr_valid  = wr_valid_r;
  assign o_wr_addr   = wr_addr_r;
  assign o_wr_data   = wr_data_r;
  assign o_frame_err = frame_err_r;

endmodule

// File: tb/tb_dac_ctrl_rx.sv
// Scoreboard bench for dac_ctrl_rx: expected writes/errors are queued as frames are
// driven and matched against o_wr_valid / o_frame_err pulses.
module tb_dac_ctrl_rx;

  logic       i_clk48   = 1'b0;
  logic       i_rst48_n = 1'b0;
  logic       i_sel_n   = 1'b1;
  logic       i_clock   = 1'b0;
  logic       i_data    = 1'b0;
  logic [7:0] o_att_l, o_att_r;
  logic [1:0] o_mute;
  logic       o_wr_valid, o_frame_err;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_data;

  dac_ctrl_rx #(.RAMP_DIV(4)) dut (
    .i_clk48(i_clk48), .i_rst48_n(i_rst48_n), .i_sel_n(i_sel_n),
    .i_clock(i_clock), .i_data(i_data),
    .o_att_l(o_att_l), .o_att_r(o_att_r), .o_mute(o_mute),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_frame_err(o_frame_err)
  );

  always #10 i_clk48 = ~i_clk48;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         exp_err   = 0;
  int         n_checks  = 0;
  int         n_pass    = 0;
  logic [7:0] mdl_att_l = 8'hFF;
  logic [7:0] mdl_att_r = 8'hFF;
  logic [1:0] mdl_mute  = 2'b00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the oldest queued expectation.
  always @(negedge i_clk48) begin
    if (i_rst48_n) begin
      if (o_wr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("wr_unexpected", o_wr_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("wr_addr", o_wr_addr, mon_e.addr);
          check_val("wr_data", o_wr_data, mon_e.data);
        end
      end
      if (o_frame_err === 1'b1) begin
        if (exp_err == 0) begin
          check_val("err_unexpected", o_frame_err, 0);
        end else begin
          exp_err--;
          check_val("err_no_wr", o_wr_valid, 0);
        end
      end
    end
  end

  task automatic model_reset();
    mdl_att_l = 8'hFF;
    mdl_att_r = 8'hFF;
    mdl_mute  = 2'b00;
    exp_q.delete();
    exp_err = 0;
  endtask

  task automatic do_reset();
    i_rst48_n = 1'b0;
    model_reset();
    repeat (3) @(negedge i_clk48);
    i_rst48_n = 1'b1;
    repeat (2) @(negedge i_clk48);
  endtask

  // Drive bits[nbits-1:0] MSB first; queue the expected outcome first.
  task automatic send_frame(input logic [16:0] bits, input int nbits);
    wr_t e;
    if (nbits == 16 && bits[15] == 1'b0) begin
      e.addr = bits[14:8];
      e.data = bits[7:0];
      exp_q.push_back(e);
      if (e.addr == 7'd16) mdl_att_l = e.data;
      if (e.addr == 7'd17) mdl_att_r = e.data;
      if (e.addr == 7'd18) mdl_mute  = e.data[1:0];
    end else begin
      exp_err++;
    end
    i_sel_n = 1'b0;
    #80;
    for (int i = nbits - 1; i >= 0; i--) begin
      i_data = bits[i];
      #80 i_clock = 1'b1;
      #80 i_clock = 1'b0;
    end
    #80 i_sel_n = 1'b1;
    #320;
  endtask

  task automatic end_group(input string tag);
    repeat (40) @(negedge i_clk48);
`ifdef DAC_CTRL_RX_SOFT_RAMP_EN
    repeat (1100) @(negedge i_clk48);
`endif
    check_val({tag, "_pend_wr"}, exp_q.size(), 0);
    check_val({tag, "_pend_err"}, exp_err, 0);
    check_val({tag, "_att_l"}, o_att_l, mdl_att_l);
    check_val({tag, "_att_r"}, o_att_r, mdl_att_r);
    check_val({tag, "_mute"}, o_mute, mdl_mute);
  endtask

  initial begin
    do_reset();
    check_val("rst_att_l", o_att_l, 8'hFF);
    check_val("rst_att_r", o_att_r, 8'hFF);
    check_val("rst_mute", o_mute, 2'b00);
    check_val("rst_wr_valid", o_wr_valid, 1'b0);
    check_val("rst_wr_addr", o_wr_addr, 7'd0);
    check_val("rst_wr_data", o_wr_data, 8'h00);
    check_val("rst_frame_err", o_frame_err, 1'b0);

`ifdef DAC_CTRL_RX_SOFT_RAMP_EN
    fork
      send_frame(17'h010FC, 16);
      begin
        int         changes  = 0;
        int         cyc      = 0;
        int         last_cyc = 0;
        logic [7:0] prev     = 8'hFF;
        logic [7:0] expv     = 8'hFE;
        while (changes < 3 && cyc < 3000) begin
          @(negedge i_clk48);
          cyc++;
          if (o_att_l !== prev) begin
            check_val("ramp_val", o_att_l, expv);
            if (changes > 0) check_val("ramp_gap", cyc - last_cyc, 4);
            last_cyc = cyc;
            prev     = o_att_l;
            expv     = expv - 8'd1;
            changes++;
          end
        end
        check_val("ramp_steps", changes, 3);
        repeat (20) @(negedge i_clk48);
        check_val("ramp_hold", o_att_l, 8'hFC);
      end
    join
    end_group("ramp");
`endif

    send_frame(17'h0105A, 16);
    end_group("wr_atl");
    send_frame(17'h01080, 16);
    send_frame(17'h01180, 16);
    end_group("pair");

    do_reset();
    send_frame(17'h0105A, 15);
    send_frame(17'h0105A, 17);
    end_group("badlen");

    send_frame(17'h09203, 16);
    end_group("read");
    send_frame(17'h01203, 16);
    end_group("mute");
    send_frame(17'h07F55, 16);
    end_group("other_addr");

    send_frame(17'h01033, 16);
    end_group("pre_mid");
    // Reset asserted and released while SEL_n is low mid-frame.
    i_sel_n = 1'b0;
    #80;
    for (int i = 0; i < 5; i++) begin
      i_data = i[0];
      #80 i_clock = 1'b1;
      #80 i_clock = 1'b0;
    end
    i_rst48_n = 1'b0;
    model_reset();
    #41;
    check_val("mid_rst_att_l", o_att_l, 8'hFF);
    check_val("mid_rst_mute", o_mute, 2'b00);
    #39 i_rst48_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      i_data = ~i[0];
      #80 i_clock = 1'b1;
      #80 i_clock = 1'b0;
    end
    #80 i_sel_n = 1'b1;
    #320;
    end_group("mid_frame");
    send_frame(17'h01122, 16);
    end_group("after_mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
